// File: rtl/arch_map_retire_pkg.sv
// Shared retire-stage definitions (sys_defs): sizing macros, the retire packet and FSM state type.
// Optional macro RETIRE_MAP_ASSERT_EN enables simulation checks inside arch_map_retire.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define N 3
`define ARCH_REG_SZ 32
`define PHYS_REG_SZ_R10K 64
`define PHYS_REG_BITS 6
`endif

package arch_map_retire_pkg;
  localparam int N_LANES       = `N;
  localparam int ARCH_REG_BITS = $clog2(`ARCH_REG_SZ);

  typedef struct packed {
    logic                      valid;
    logic                      has_dest;
    logic [ARCH_REG_BITS-1:0]  arch_reg;
    logic [`PHYS_REG_BITS-1:0] preg;
    logic                      mispredict;
  } RETIRE_PACKET;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    DRAIN   = 2'd2
  } retire_state_e;
endpackage

// File: rtl/arch_map_retire_if.sv
// Retire-group bus between the ROB head (master) and the architectural map retire stage (slave).
interface arch_map_retire_if #(
  parameter int WIDTH     = `N,
  parameter int ARCH_REGS = `ARCH_REG_SZ,
  parameter int PB        = `PHYS_REG_BITS
);
  localparam int AB = $clog2(ARCH_REGS);

  logic [WIDTH-1:0]                 retire_valid;
  logic [WIDTH-1:0]                 retire_has_dest;
  logic [WIDTH-1:0][AB-1:0]         retire_arch_reg;
  logic [WIDTH-1:0][PB-1:0]         retire_preg;
  logic [WIDTH-1:0]                 retire_mispredict;
  logic                             retire_ready;
  logic [WIDTH-1:0]                 free_reg_request;
  logic [WIDTH-1:0][PB-1:0]         retired_pregs;
  logic                             branch_mispredict;
  logic [ARCH_REGS-1:0][PB-1:0]     arch_map_mispredict_input;

  modport master (
    output retire_valid, retire_has_dest, retire_arch_reg, retire_preg, retire_mispredict,
    input  retire_ready, free_reg_request, retired_pregs, branch_mispredict,
    input  arch_map_mispredict_input
  );

  modport slave (
    input  retire_valid, retire_has_dest, retire_arch_reg, retire_preg, retire_mispredict,
    output retire_ready, free_reg_request, retired_pregs, branch_mispredict,
    output arch_map_mispredict_input
  );
endinterface

// File: rtl/arch_map_retire_told_resolve.sv
// Combinational retire-group resolve: squashes lanes younger than an effective mispredict and
// forwards the previous mapping (Told) through older lanes of the same group.
module retire_told_resolve
  import arch_map_retire_pkg::*;
#(
  parameter int WIDTH     = `N,
  parameter int ARCH_REGS = `ARCH_REG_SZ,
  parameter int PB        = `PHYS_REG_BITS
) (
  input  logic                         accept,
  input  RETIRE_PACKET [WIDTH-1:0]     pkts,
  input  logic [ARCH_REGS-1:0][PB-1:0] arch_map,
  output logic [WIDTH-1:0]             effective,
  output logic [WIDTH-1:0]             writes,
  output logic [WIDTH-1:0][PB-1:0]     told,
  output logic                         any_mispredict
);

  // Effective lanes stop at (and include) the oldest mispredicting lane.
  always_comb begin
    logic squash;
    squash         = 1'b0;
    effective      = '0;
    writes         = '0;
    any_mispredict = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (accept && pkts[i].valid && !squash) begin
        effective[i] = 1'b1;
        writes[i]    = pkts[i].has_dest && (pkts[i].arch_reg != '0);
        if (pkts[i].mispredict) begin
          squash         = 1'b1;
          any_mispredict = 1'b1;
        end else begin
          squash = squash;
        end
      end else begin
        effective[i] = 1'b0;
      end
    end
  end

  // Ascending scan leaves the youngest older writer of the same register as Told.
  always_comb begin
    told = '0;
    for (int i = 0; i < WIDTH; i++) begin
      told[i] = arch_map[pkts[i].arch_reg];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && writes[j] && (pkts[j].arch_reg == pkts[i].arch_reg)) begin
          told[i] = pkts[j].preg;
        end else begin
          told[i] = told[i];
        end
      end
    end
  end

endmodule

// File: rtl/arch_map_retire.sv
// Architectural (retirement) register map with lane-aligned free outputs and mispredict recovery FSM.
// Defining RETIRE_MAP_ASSERT_EN adds simulation-only consistency checks; ports and timing are unchanged.
module arch_map_retire
  import arch_map_retire_pkg::*;
#(
  parameter int ARCH_REGS = `ARCH_REG_SZ,
  parameter int PHYS_REGS = `PHYS_REG_SZ_R10K,
  parameter int WIDTH     = `N
) (
  input  logic             clock,
  input  logic             reset,
  arch_map_retire_if.slave rif
);
  localparam int PB = `PHYS_REG_BITS;

  RETIRE_PACKET [WIDTH-1:0]     pkts_s;
  logic [WIDTH-1:0]             effective_s;
  logic [WIDTH-1:0]             writes_s;
  logic [WIDTH-1:0][PB-1:0]     told_s;
  logic                         any_mispredict_s;

  logic [ARCH_REGS-1:0][PB-1:0] arch_map_r;
  retire_state_e                state_r;
  logic                         ready_r;
  logic                         branch_r;
  logic [WIDTH-1:0]             free_r;
  logic [WIDTH-1:0][PB-1:0]     retired_r;

  // Pack the interface lanes into retire packets.
  always_comb begin
    pkts_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pkts_s[i].valid      = rif.retire_valid[i];
      pkts_s[i].has_dest   = rif.retire_has_dest[i];
      pkts_s[i].arch_reg   = rif.retire_arch_reg[i];
      pkts_s[i].preg       = rif.retire_preg[i];
      pkts_s[i].mispredict = rif.retire_mispredict[i];
    end
  end

  retire_told_resolve #(
    .WIDTH     (WIDTH),
    .ARCH_REGS (ARCH_REGS),
    .PB        (PB)
  ) u_resolve (
    .accept         (ready_r),
    .pkts           (pkts_s),
    .arch_map       (arch_map_r),
    .effective      (effective_s),
    .writes         (writes_s),
    .told           (told_s),
    .any_mispredict (any_mispredict_s)
  );

  // Map update, free outputs and RUN/RECOVER/DRAIN sequencing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        arch_map_r[i] <= PB'(i % PHYS_REGS);
      end
      state_r   <= RUN;
      ready_r   <= 1'b1;
      branch_r  <= 1'b0;
      free_r    <= '0;
      retired_r <= '0;
    end else begin
      // Later (younger) lanes overwrite earlier ones, so the youngest T wins.
      for (int i = 0; i < WIDTH; i++) begin
        if (writes_s[i]) begin
          arch_map_r[pkts_s[i].arch_reg] <= pkts_s[i].preg;
        end
        free_r[i]    <= writes_s[i];
        retired_r[i] <= writes_s[i] ? told_s[i] : {PB{1'b0}};
      end
      case (state_r)
        RUN: begin
          if (any_mispredict_s) begin
            state_r  <= RECOVER;
            ready_r  <= 1'b0;
            branch_r <= 1'b1;
          end else begin
            state_r  <= RUN;
            ready_r  <= 1'b1;
            branch_r <= 1'b0;
          end
        end
        RECOVER: begin
          state_r  <= DRAIN;
          ready_r  <= 1'b0;
          branch_r <= 1'b0;
        end
        DRAIN: begin
          state_r  <= RUN;
          ready_r  <= 1'b1;
          branch_r <= 1'b0;
        end
        default: begin
          state_r  <= RUN;
          ready_r  <= 1'b1;
          branch_r <= 1'b0;
        end
      endcase
    end
  end

  assign rif.retire_ready              = ready_r;
  assign rif.free_reg_request          = free_r;
  assign rif.retired_pregs             = retired_r;
  assign rif.branch_mispredict         = branch_r;
  assign rif.arch_map_mispredict_input = arch_map_r;

`ifdef RETIRE_MAP_ASSERT_EN
  arch_map_retire_chk #(
    .WIDTH     (WIDTH),
    .ARCH_REGS (ARCH_REGS),
    .PB        (PB)
  ) u_chk (
    .clock    (clock),
    .reset    (reset),
    .writes   (writes_s),
    .pregs    (rif.retire_preg),
    .arch_map (arch_map_r),
    .free     (free_r),
    .freed    (retired_r)
  );
`else
  logic unused_s;
  assign unused_s = ^effective_s;
`endif

endmodule

`ifdef RETIRE_MAP_ASSERT_EN
module arch_map_retire_chk #(
  parameter int WIDTH     = `N,
  parameter int ARCH_REGS = `ARCH_REG_SZ,
  parameter int PB        = `PHYS_REG_BITS
) (
  input logic                         clock,
  input logic                         reset,
  input logic [WIDTH-1:0]             writes,
  input logic [WIDTH-1:0][PB-1:0]     pregs,
  input logic [ARCH_REGS-1:0][PB-1:0] arch_map,
  input logic [WIDTH-1:0]             free,
  input logic [WIDTH-1:0][PB-1:0]     freed
);
  // A new mapping must not already be live; one cycle must not free a preg twice.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        for (int a = 0; a < ARCH_REGS; a++) begin
          assert (!(writes[i] && arch_map[a] == pregs[i]))
            else $error("retire preg %0d already mapped to arch reg %0d", pregs[i], a);
        end
        for (int j = 0; j < WIDTH; j++) begin
          assert (!(j > i && free[i] && free[j] && freed[i] == freed[j]))
            else $error("preg %0d freed on lanes %0d and %0d", freed[i], i, j);
        end
      end
    end
  end
endmodule
`endif
